imm_inst_encoder: RTL and testbench
===================================

// Module: imm_inst_encoder
// PURPOSE
// - Bulk I-type ALU instruction encoder/loader; inverse of the I-type decode path.
// - Accepts {alu_control, rs1, rd, imm} requests over valid/ready and packs each into a
//   32-bit RV32I OP-IMM word (opcode 7'h13).
// - Writes words to consecutive instruction-memory addresses from a programmed base.
// - Used by the self-test/boot path to build programs in IMEM without an external assembler.
// PARAMETERS
// - ADDR_W  32  IMEM byte-address width; address steps by 4, wraps modulo 2^ADDR_W.
// - CNT_W   16  width of the instruction-count field.
// - ERR_W   8   width of the saturating error counter.
// PORTS
// - clk              in   1       single clock, rising edge
// - rst_n            in   1       asynchronous, active-low reset
// - start            in   1       1-cycle pulse; latches base_addr and inst_count
// - base_addr        in   ADDR_W  first IMEM byte address (bits [1:0] forced to 0)
// - inst_count       in   CNT_W   number of requests to consume in this job
// - busy             out  1       job in progress (RUN or DRAIN)
// - done             out  1       1-cycle pulse when the job's last word is accepted by IMEM
// - req_valid        in   1       request valid
// - req_ready        out  1       request accepted when req_valid && req_ready
// - req_alu_control  in   5       `ADDI..`ANDI code (processor_defines.sv)
// - req_rs1, req_rd  in   5 each  register indices
// - req_imm          in   12      immediate; for shifts only [4:0] is the shamt
// - mem_we           out  1       write valid (held until mem_ready)
// - mem_ready        in   1       IMEM accepts write when mem_we && mem_ready
// - mem_addr         out  ADDR_W  write byte address
// - mem_wdata        out  32      encoded instruction
// - err_count        out  ERR_W   rejected requests; saturates at all-ones; cleared on start
// - last_err_code    out  5       alu_control of the most recent rejected request
// BEHAVIOUR
// - Reset: FSM=IDLE; busy, done, req_ready, mem_we = 0; mem_addr, mem_wdata, err_count,
//   last_err_code = 0; output register empty. Reset mid-job aborts; in-flight word dropped.
// - FSM: IDLE -start-> RUN (inst_count==0: IDLE -start-> DONE directly).
//   RUN -> DRAIN once accepted==inst_count. DRAIN -> DONE when output register empties.
//   DONE is 1 cycle (done=1) -> IDLE. start ignored unless IDLE.
// - req_ready = (state==RUN) && (accepted<inst_count) && (!mem_we || mem_ready).
//   Combinational from state and mem_ready only; never from req_valid.
// - Latency: handshake in cycle N -> mem_we/addr/wdata valid in cycle N+1.
//   One-entry output register; sustains 1 word/cycle while mem_ready=1.
// - Encoding: {imm[11:0], rs1, funct3, rd, 7'h13}.
//   funct3: ADDI 0, SLLI 1, SLTI 2, SLTIU 3, XORI 4, SRLI/SRAI 5, ORI 6, ANDI 7.
//   Shifts: imm[11:5] = 7'h00 (SLLI/SRLI) or 7'h20 (SRAI); imm[4:0] = req_imm[4:0].
// - Rejection: alu_control not one of the 9 codes, or shift with req_imm[11:5] != 0.
//   Request is still consumed and counted; NOP 32'h0000_0013 written in its place so
//   addresses stay aligned; err_count++ (saturating); last_err_code updated.
// - mem_addr: starts at {base_addr[ADDR_W-1:2],2'b00}, +4 per IMEM-accepted word,
//   wraps silently past all-ones.
// - mem_we, mem_addr, mem_wdata stable while mem_we && !mem_ready.
// STRUCTURE
// - Package imm_enc_pkg: OP_IMM = 7'h13, funct3 enum, SRA_FUNCT7 = 7'h20,
//   NOP_WORD = 32'h13, state enum {IDLE, RUN, DRAIN, DONE}.
// - Sub-module imm_inst_pack (combinational): alu_control/rs1/rd/imm -> {word, illegal}.
// - Top holds FSM, counters, output register, error logic.
// TESTING
// - base=0x100, cnt=1, ADDI rd=5 rs1=1 imm=0xFFF -> one write 0xFFF08293 @0x100; done 1 cyc later.
// - SRAI rd=3 rs1=2 imm=7, then SLLI imm=0x020 -> 0x40715193 @A, 0x00000013 @A+4;
//   err_count=1; last_err_code=`SLLI.
// - cnt=4 back-to-back, mem_ready low 3 cycles mid-burst -> output held stable;
//   addrs +4 each; no loss or duplication.
// - base=0xFFFF_FFFC, cnt=2 -> writes @0xFFFFFFFC then @0x0; start while busy ignored.
// - cnt=0 -> done pulses 1 cycle after start; no mem_we; req_ready stays 0.
// - Reset mid-job, then 8 random legal requests -> each word round-trips through the
//   I-type decoder to the original fields and ALU code.

Source files
------------

// File: rtl/imm_inst_encoder_pkg.sv
// ---------------------------------------------------------------------------
// imm_enc_pkg
// Shared constants and types for the I-type (OP-IMM) instruction encoder:
//   - RV32I OP-IMM opcode, shift funct7 values and the canonical NOP word
//   - 5-bit ALU control codes accepted on the request port
//   - funct3 encoding enum and the encoder FSM state enum
// ---------------------------------------------------------------------------
package imm_enc_pkg;

  localparam logic [6:0]  OP_IMM       = 7'h13;
  localparam logic [6:0]  SHIFT_FUNCT7 = 7'h00;
  localparam logic [6:0]  SRA_FUNCT7   = 7'h20;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0013;

  localparam logic [4:0] ALU_ADDI  = 5'd0;
  localparam logic [4:0] ALU_SLTI  = 5'd1;
  localparam logic [4:0] ALU_SLTIU = 5'd2;
  localparam logic [4:0] ALU_XORI  = 5'd3;
  localparam logic [4:0] ALU_ORI   = 5'd4;
  localparam logic [4:0] ALU_ANDI  = 5'd5;
  localparam logic [4:0] ALU_SLLI  = 5'd6;
  localparam logic [4:0] ALU_SRLI  = 5'd7;
  localparam logic [4:0] ALU_SRAI  = 5'd8;

  typedef enum logic [2:0] {
    F3_ADDI  = 3'd0,
    F3_SLLI  = 3'd1,
    F3_SLTI  = 3'd2,
    F3_SLTIU = 3'd3,
    F3_XORI  = 3'd4,
    F3_SR    = 3'd5,
    F3_ORI   = 3'd6,
    F3_ANDI  = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/imm_inst_encoder_if.sv
// ---------------------------------------------------------------------------
// imm_inst_encoder_if
// Bundles the job control, request handshake and IMEM write bus of the
// instruction encoder.
//   master : the side that launches jobs, supplies requests and plays IMEM
//   slave  : the encoder itself
// Signals: start/base_addr/inst_count/busy/done (job control),
//          req_valid/req_ready/req_alu_control/req_rs1/req_rd/req_imm (requests),
//          mem_we/mem_ready/mem_addr/mem_wdata (IMEM writes),
//          err_count/last_err_code (rejection status).
// ---------------------------------------------------------------------------
interface imm_inst_encoder_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 8
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  inst_count;
  logic              busy;
  logic              done;

  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_alu_control;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rd;
  logic [11:0]       req_imm;

  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  logic [ERR_W-1:0]  err_count;
  logic [4:0]        last_err_code;

  modport master (
    output start, base_addr, inst_count, req_valid, req_alu_control,
           req_rs1, req_rd, req_imm, mem_ready,
    input  busy, done, req_ready, mem_we, mem_addr, mem_wdata,
           err_count, last_err_code
  );

  modport slave (
    input  start, base_addr, inst_count, req_valid, req_alu_control,
           req_rs1, req_rd, req_imm, mem_ready,
    output busy, done, req_ready, mem_we, mem_addr, mem_wdata,
           err_count, last_err_code
  );

endinterface

// File: rtl/imm_inst_encoder_pack.sv
// ---------------------------------------------------------------------------
// imm_inst_pack
// Purely combinational packer: turns an ALU control code plus rs1/rd/imm into
// a 32-bit RV32I OP-IMM word and flags requests that cannot be encoded.
// Ports:
//   i_aluControl  5   ALU operation code (ALU_* in imm_enc_pkg)
//   i_rs1, i_rd   5   register indices
//   i_imm         12  immediate; shifts use only [4:0] as shamt
//   o_word        32  encoded instruction, NOP when illegal
//   o_illegal     1   unknown code, or shift with non-zero imm[11:5]
// ---------------------------------------------------------------------------
module imm_inst_pack
  import imm_enc_pkg::*;
(
  input  logic [4:0]  i_aluControl,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rd,
  input  logic [11:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  funct3_e     w_funct3;
  logic [11:0] w_immField;

  // Shifts rebuild the upper immediate from the funct7 constant, so any
  // stray bits the requester put in imm[11:5] make the request illegal
  // rather than silently turning SRLI into SRAI. Illegal requests still
  // produce a NOP so the program image keeps its slot.
  always_comb begin
    w_funct3   = F3_ADDI;
    w_immField = i_imm;
    o_illegal  = 1'b0;
    case (i_aluControl)
      ALU_ADDI:  w_funct3 = F3_ADDI;
      ALU_SLTI:  w_funct3 = F3_SLTI;
      ALU_SLTIU: w_funct3 = F3_SLTIU;
      ALU_XORI:  w_funct3 = F3_XORI;
      ALU_ORI:   w_funct3 = F3_ORI;
      ALU_ANDI:  w_funct3 = F3_ANDI;
      ALU_SLLI: begin
        w_funct3   = F3_SLLI;
        w_immField = {SHIFT_FUNCT7, i_imm[4:0]};
        o_illegal  = |i_imm[11:5];
      end
      ALU_SRLI: begin
        w_funct3   = F3_SR;
        w_immField = {SHIFT_FUNCT7, i_imm[4:0]};
        o_illegal  = |i_imm[11:5];
      end
      ALU_SRAI: begin
        w_funct3   = F3_SR;
        w_immField = {SRA_FUNCT7, i_imm[4:0]};
        o_illegal  = |i_imm[11:5];
      end
      default: o_illegal = 1'b1;
    endcase
    o_word = o_illegal ? NOP_WORD : {w_immField, i_rs1, w_funct3, i_rd, OP_IMM};
  end

endmodule

// File: rtl/imm_inst_encoder.sv
// ---------------------------------------------------------------------------
// imm_inst_encoder
// Bulk OP-IMM instruction loader. A start pulse latches a base address and a
// request count; each accepted request is packed into an RV32I word and
// written to consecutive IMEM addresses through a one-entry output register.
// Ports:
//   clk    1  rising-edge clock
//   rst_n  1  asynchronous active-low reset
//   bus       imm_inst_encoder_if.slave (job control, requests, IMEM writes,
//             error status)
// ---------------------------------------------------------------------------
module imm_inst_encoder
  import imm_enc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  imm_inst_encoder_if.slave bus
);

  state_e            r_state;
  state_e            w_nextState;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_accepted;
  logic              r_memWe;
  logic [31:0]       r_wdata;
  logic [ERR_W-1:0]  r_errCount;
  logic [4:0]        r_lastErr;

  logic [31:0]       w_packedWord;
  logic              w_illegal;
  logic              w_reqReady;
  logic              w_reqFire;
  logic              w_memFire;
  logic              w_startAccept;
  logic              w_lastFire;

  imm_inst_pack u_pack (
    .i_aluControl (bus.req_alu_control),
    .i_rs1        (bus.req_rs1),
    .i_rd         (bus.req_rd),
    .i_imm        (bus.req_imm),
    .o_word       (w_packedWord),
    .o_illegal    (w_illegal)
  );

  // Ready never looks at req_valid; a request can enter whenever the output
  // register is empty or is being drained by IMEM in this same cycle.
  assign w_reqReady    = (r_state == RUN) && (r_accepted < r_count) &&
                         (!r_memWe || bus.mem_ready);
  assign w_reqFire     = bus.req_valid && w_reqReady;
  assign w_memFire     = r_memWe && bus.mem_ready;
  assign w_startAccept = (r_state == IDLE) && bus.start;
  assign w_lastFire    = w_reqFire && ((r_accepted + CNT_W'(1)) == r_count);

  assign bus.req_ready     = w_reqReady;
  assign bus.busy          = (r_state == RUN) || (r_state == DRAIN);
  assign bus.done          = (r_state == DONE);
  assign bus.mem_we        = r_memWe;
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wdata     = r_wdata;
  assign bus.err_count     = r_errCount;
  assign bus.last_err_code = r_lastErr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Leaving RUN on the handshake of the final request lets DRAIN see the
  // last word in the output register immediately, so done lands in the
  // cycle right after IMEM takes that word. A zero-length job goes straight
  // to DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = (bus.inst_count == '0) ? DONE : RUN;
      RUN:     if (w_lastFire) w_nextState = DRAIN;
      DRAIN:   if (!r_memWe || bus.mem_ready) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Job bookkeeping: start re-arms the address, count and error counter;
  // afterwards the address only advances on IMEM acceptance so a stalled
  // write keeps its address, and it wraps naturally at the top of memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_accepted <= '0;
      r_errCount <= '0;
      r_lastErr  <= '0;
    end else if (w_startAccept) begin
      r_addr     <= {bus.base_addr[ADDR_W-1:2], 2'b00};
      r_count    <= bus.inst_count;
      r_accepted <= '0;
      r_errCount <= '0;
    end else begin
      if (w_memFire) r_addr <= r_addr + ADDR_W'(4);
      if (w_reqFire) r_accepted <= r_accepted + CNT_W'(1);
      if (w_reqFire && w_illegal) begin
        if (r_errCount != {ERR_W{1'b1}}) r_errCount <= r_errCount + ERR_W'(1);
        r_lastErr <= bus.req_alu_control;
      end
    end
  end

  // One-entry output register. A new word overwrites the slot only when the
  // handshake fired, which already guarantees the old word was taken, so the
  // write stays frozen while IMEM holds mem_ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memWe <= 1'b0;
      r_wdata <= '0;
    end else if (w_reqFire) begin
      r_memWe <= 1'b1;
      r_wdata <= w_packedWord;
    end else if (w_memFire) begin
      r_memWe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_inst_encoder
// Self-checking bench for imm_inst_encoder. Requests are driven one cycle
// after the rising edge, outputs are observed on the falling edge, and the
// expected words come from an arithmetic RV32I encoder/decoder kept here.
// ---------------------------------------------------------------------------
module tb_imm_inst_encoder;

  localparam logic [4:0] A_ADDI  = imm_enc_pkg::ALU_ADDI;
  localparam logic [4:0] A_SLTI  = imm_enc_pkg::ALU_SLTI;
  localparam logic [4:0] A_SLTIU = imm_enc_pkg::ALU_SLTIU;
  localparam logic [4:0] A_XORI  = imm_enc_pkg::ALU_XORI;
  localparam logic [4:0] A_ORI   = imm_enc_pkg::ALU_ORI;
  localparam logic [4:0] A_ANDI  = imm_enc_pkg::ALU_ANDI;
  localparam logic [4:0] A_SLLI  = imm_enc_pkg::ALU_SLLI;
  localparam logic [4:0] A_SRLI  = imm_enc_pkg::ALU_SRLI;
  localparam logic [4:0] A_SRAI  = imm_enc_pkg::ALU_SRAI;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_inst_encoder_if bus ();

  imm_inst_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int testsRun = 0;
  int testsFailed = 0;

  logic [4:0]  legalCodes [9] = '{A_ADDI, A_SLTI, A_SLTIU, A_XORI, A_ORI,
                                  A_ANDI, A_SLLI, A_SRLI, A_SRAI};

  // Observation of the IMEM side: accepted writes, stall stability,
  // done pulses and any req_ready activity, all sampled on the falling edge.
  logic [31:0] capAddr [$];
  logic [31:0] capData [$];
  int          capCycle [$];
  int          cycleNo = 0;
  int          doneCnt = 0;
  int          lastDoneCycle = 0;
  int          stallViol = 0;
  int          stallCycles = 0;
  int          readySeen = 0;
  bit          stallPrev = 1'b0;
  logic [31:0] stallAddr, stallData;

  always @(negedge clk) begin
    cycleNo++;
    if (rst_n === 1'b1) begin
      if (bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) begin
        capAddr.push_back(bus.mem_addr);
        capData.push_back(bus.mem_wdata);
        capCycle.push_back(cycleNo);
      end
      if (stallPrev && (bus.mem_we !== 1'b1 || bus.mem_addr !== stallAddr ||
                        bus.mem_wdata !== stallData))
        stallViol++;
      stallPrev = (bus.mem_we === 1'b1 && bus.mem_ready !== 1'b1);
      if (stallPrev) stallCycles++;
      stallAddr = bus.mem_addr;
      stallData = bus.mem_wdata;
      if (bus.done === 1'b1) begin
        doneCnt++;
        lastDoneCycle = cycleNo;
      end
      if (bus.req_ready === 1'b1) readySeen++;
    end else begin
      stallPrev = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: RV32I OP-IMM rules written as plain arithmetic.
  function automatic bit refLegal(input logic [4:0] code, input logic [11:0] imm);
    bool_check: begin end
    if (code == A_SLLI || code == A_SRLI || code == A_SRAI) return (imm < 12'd32);
    return (code == A_ADDI || code == A_SLTI || code == A_SLTIU || code == A_XORI ||
            code == A_ORI || code == A_ANDI);
  endfunction

  function automatic logic [31:0] refEncode(input logic [4:0] code, input logic [4:0] rs1,
                                            input logic [4:0] rd, input logic [11:0] imm);
    longint f3, immF, r;
    if (!refLegal(code, imm)) return 32'h0000_0013;
    immF = longint'(imm);
    f3 = 0;
    if      (code == A_ADDI)  f3 = 0;
    else if (code == A_SLLI)  f3 = 1;
    else if (code == A_SLTI)  f3 = 2;
    else if (code == A_SLTIU) f3 = 3;
    else if (code == A_XORI)  f3 = 4;
    else if (code == A_SRLI)  f3 = 5;
    else if (code == A_SRAI)  begin f3 = 5; immF = immF + 1024; end
    else if (code == A_ORI)   f3 = 6;
    else                      f3 = 7;
    r = immF * 1048576 + longint'(rs1) * 32768 + f3 * 4096 + longint'(rd) * 128 + 19;
    return r[31:0];
  endfunction

  function automatic void refDecode(input logic [31:0] w, output logic [6:0] opc,
                                    output logic [4:0] code, output logic [4:0] rs1,
                                    output logic [4:0] rd, output logic [11:0] imm);
    int f3;
    opc = 7'(w % 128);
    rd  = 5'((w / 128) % 32);
    f3  = int'((w / 4096) % 8);
    rs1 = 5'((w / 32768) % 32);
    imm = 12'(w / 1048576);
    code = A_ADDI;
    case (f3)
      0: code = A_ADDI;
      1: begin code = A_SLLI; imm = imm % 32; end
      2: code = A_SLTI;
      3: code = A_SLTIU;
      4: code = A_XORI;
      5: begin code = (imm / 32 == 32) ? A_SRAI : A_SRLI; imm = imm % 32; end
      6: code = A_ORI;
      default: code = A_ANDI;
    endcase
  endfunction

  task automatic clearMon();
    capAddr.delete();
    capData.delete();
    capCycle.delete();
    doneCnt = 0;
    stallViol = 0;
    stallCycles = 0;
    readySeen = 0;
  endtask

  task automatic pulseStart(input logic [31:0] base, input logic [15:0] cnt);
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.inst_count = cnt;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic sendReq(input logic [4:0] code, input logic [4:0] rs1, input logic [4:0] rd,
                         input logic [11:0] imm, output bit ok);
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_alu_control = code;
    bus.req_rs1 = rs1;
    bus.req_rd = rd;
    bus.req_imm = imm;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic waitDone(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic genLegal(output logic [4:0] code, output logic [4:0] rs1,
                          output logic [4:0] rd, output logic [11:0] imm);
    code = legalCodes[$urandom_range(0, 8)];
    rs1 = 5'($urandom);
    rd = 5'($urandom);
    imm = 12'($urandom);
    if (code == A_SLLI || code == A_SRLI || code == A_SRAI) imm = imm % 32;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    testsRun++; if (bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    testsRun++; if (bus.req_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.req_ready); end
    testsRun++; if (bus.mem_we !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_we: got %b expected 0", bus.mem_we); end
    testsRun++; if (bus.mem_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %h expected 0", bus.mem_addr); end
    testsRun++; if (bus.mem_wdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_wdata: got %h expected 0", bus.mem_wdata); end
    testsRun++; if (bus.err_count !== 8'h0) begin testsFailed++; $display("[TB] FAIL reset_err: got %h expected 0", bus.err_count); end
    testsRun++; if (bus.last_err_code !== 5'h0) begin testsFailed++; $display("[TB] FAIL reset_lasterr: got %h expected 0", bus.last_err_code); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addi_single();
    bit ok, dok;
    clearMon();
    pulseStart(32'h100, 16'd1);
    sendReq(A_ADDI, 5'd1, 5'd5, 12'hFFF, ok);
    bus.req_valid = 1'b0;
    waitDone(50, dok);
    repeat (3) @(posedge clk); #1;
    testsRun++; if (!ok || !dok) begin testsFailed++; $display("[TB] FAIL addi_progress: accepted %b done %b expected 1 1", ok, dok); end
    testsRun++; if (capData.size() != 1) begin testsFailed++; $display("[TB] FAIL addi_count: got %0d writes expected 1", capData.size()); end
    if (capData.size() >= 1) begin
      testsRun++; if (capAddr[0] !== 32'h100) begin testsFailed++; $display("[TB] FAIL addi_addr: got %h expected 00000100", capAddr[0]); end
      testsRun++; if (capData[0] !== 32'hFFF08293) begin testsFailed++; $display("[TB] FAIL addi_word: got %h expected fff08293", capData[0]); end
      testsRun++; if (lastDoneCycle != capCycle[0] + 1) begin testsFailed++; $display("[TB] FAIL addi_done_time: got cycle %0d expected %0d", lastDoneCycle, capCycle[0] + 1); end
    end
    testsRun++; if (doneCnt != 1) begin testsFailed++; $display("[TB] FAIL addi_done_pulses: got %0d expected 1", doneCnt); end
    testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL addi_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_shift_error();
    bit ok1, ok2, dok;
    logic [31:0] base, a;
    base = $urandom_range(0, 32'h0FFF_FFFF);
    a = (base / 4) * 4;
    clearMon();
    pulseStart(base, 16'd2);
    sendReq(A_SRAI, 5'd2, 5'd3, 12'h007, ok1);
    sendReq(A_SLLI, 5'd6, 5'd4, 12'h020, ok2);
    bus.req_valid = 1'b0;
    waitDone(50, dok);
    testsRun++; if (!ok1 || !ok2 || !dok) begin testsFailed++; $display("[TB] FAIL shift_progress: acc %b %b done %b expected 1 1 1", ok1, ok2, dok); end
    testsRun++; if (capData.size() != 2) begin testsFailed++; $display("[TB] FAIL shift_count: got %0d writes expected 2", capData.size()); end
    if (capData.size() >= 2) begin
      testsRun++; if (capData[0] !== 32'h40715193) begin testsFailed++; $display("[TB] FAIL srai_word: got %h expected 40715193", capData[0]); end
      testsRun++; if (capAddr[0] !== a) begin testsFailed++; $display("[TB] FAIL srai_addr: got %h expected %h", capAddr[0], a); end
      testsRun++; if (capData[1] !== 32'h00000013) begin testsFailed++; $display("[TB] FAIL reject_nop: got %h expected 00000013", capData[1]); end
      testsRun++; if (capAddr[1] !== a + 32'd4) begin testsFailed++; $display("[TB] FAIL reject_addr: got %h expected %h", capAddr[1], a + 32'd4); end
    end
    testsRun++; if (bus.err_count !== 8'd1) begin testsFailed++; $display("[TB] FAIL err_count: got %0d expected 1", bus.err_count); end
    testsRun++; if (bus.last_err_code !== A_SLLI) begin testsFailed++; $display("[TB] FAIL last_err_code: got %0d expected %0d", bus.last_err_code, A_SLLI); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  gc [4];
    logic [4:0]  gs [4];
    logic [4:0]  gd [4];
    logic [11:0] gi [4];
    logic [31:0] base;
    bit okAll, dok;
    okAll = 1'b1;
    base = $urandom & 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) genLegal(gc[i], gs[i], gd[i], gi[i]);
    clearMon();
    pulseStart(base, 16'd4);
    testsRun++; if (bus.err_count !== 8'd0) begin testsFailed++; $display("[TB] FAIL err_cleared: got %0d expected 0", bus.err_count); end
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          bit ok;
          sendReq(gc[i], gs[i], gd[i], gi[i], ok);
          if (!ok) okAll = 1'b0;
        end
        bus.req_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.mem_ready = 1'b1;
      end
    join
    waitDone(50, dok);
    testsRun++; if (!okAll || !dok) begin testsFailed++; $display("[TB] FAIL b2b_progress: acc %b done %b expected 1 1", okAll, dok); end
    testsRun++; if (capData.size() != 4) begin testsFailed++; $display("[TB] FAIL b2b_count: got %0d writes expected 4", capData.size()); end
    for (int i = 0; i < 4 && i < capData.size(); i++) begin
      testsRun++; if (capData[i] !== refEncode(gc[i], gs[i], gd[i], gi[i]) || capAddr[i] !== base + 32'(4 * i)) begin
        testsFailed++;
        $display("[TB] FAIL b2b_word%0d: got %h@%h expected %h@%h", i, capData[i], capAddr[i], refEncode(gc[i], gs[i], gd[i], gi[i]), base + 32'(4 * i));
      end
    end
    testsRun++; if (stallCycles != 3) begin testsFailed++; $display("[TB] FAIL b2b_stall_cycles: got %0d expected 3", stallCycles); end
    testsRun++; if (stallViol != 0) begin testsFailed++; $display("[TB] FAIL b2b_held_stable: got %0d changes expected 0", stallViol); end
  endtask

  task automatic test_wrap();
    bit ok1, ok2, dok;
    logic [31:0] w0, w1;
    w0 = refEncode(A_ORI, 5'd7, 5'd8, 12'h5A5);
    w1 = refEncode(A_SRLI, 5'd9, 5'd10, 12'h01F);
    clearMon();
    pulseStart(32'hFFFF_FFFC, 16'd2);
    sendReq(A_ORI, 5'd7, 5'd8, 12'h5A5, ok1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    testsRun++; if (bus.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL wrap_busy: got %b expected 1", bus.busy); end
    @(posedge clk); #1;
    pulseStart(32'h0000_0040, 16'd7);
    sendReq(A_SRLI, 5'd9, 5'd10, 12'h01F, ok2);
    bus.req_valid = 1'b0;
    waitDone(50, dok);
    repeat (4) @(posedge clk); #1;
    testsRun++; if (!ok1 || !ok2 || !dok) begin testsFailed++; $display("[TB] FAIL wrap_progress: acc %b %b done %b expected 1 1 1", ok1, ok2, dok); end
    testsRun++; if (capData.size() != 2) begin testsFailed++; $display("[TB] FAIL wrap_count: got %0d writes expected 2", capData.size()); end
    if (capData.size() >= 2) begin
      testsRun++; if (capAddr[0] !== 32'hFFFF_FFFC || capData[0] !== w0) begin testsFailed++; $display("[TB] FAIL wrap_first: got %h@%h expected %h@fffffffc", capData[0], capAddr[0], w0); end
      testsRun++; if (capAddr[1] !== 32'h0 || capData[1] !== w1) begin testsFailed++; $display("[TB] FAIL wrap_second: got %h@%h expected %h@00000000", capData[1], capAddr[1], w1); end
    end
    testsRun++; if (doneCnt != 1) begin testsFailed++; $display("[TB] FAIL wrap_busy_start_ignored: got %0d done pulses expected 1", doneCnt); end
    testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL wrap_idle_after: got busy %b expected 0", bus.busy); end
  endtask

  task automatic test_zero_count();
    clearMon();
    bus.start = 1'b1;
    bus.base_addr = 32'h2000;
    bus.inst_count = 16'd0;
    @(negedge clk);
    testsRun++; if (bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_done_early: got %b expected 0", bus.done); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    testsRun++; if (bus.done !== 1'b1) begin testsFailed++; $display("[TB] FAIL zero_done_pulse: got %b expected 1", bus.done); end
    @(negedge clk);
    testsRun++; if (bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_done_width: got %b expected 0", bus.done); end
    repeat (4) @(negedge clk);
    testsRun++; if (capData.size() != 0) begin testsFailed++; $display("[TB] FAIL zero_no_write: got %0d writes expected 0", capData.size()); end
    testsRun++; if (readySeen != 0) begin testsFailed++; $display("[TB] FAIL zero_no_ready: got %0d ready cycles expected 0", readySeen); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midjob();
    logic [4:0]  gc [8];
    logic [4:0]  gs [8];
    logic [4:0]  gd [8];
    logic [11:0] gi [8];
    logic [6:0]  dOpc;
    logic [4:0]  dCode, dRs1, dRd;
    logic [11:0] dImm;
    logic [31:0] base;
    bit ok, okAll, dok, stopRand;
    pulseStart(32'h300, 16'd6);
    sendReq(A_ADDI, 5'd1, 5'd2, 12'h123, ok);
    sendReq(A_XORI, 5'd3, 5'd4, 12'h456, ok);
    bus.req_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    testsRun++; if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.req_ready !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL midjob_reset: got busy %b we %b ready %b expected 0 0 0", bus.busy, bus.mem_we, bus.req_ready);
    end
    testsRun++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL midjob_reset_bus: got %h@%h expected 0@0", bus.mem_wdata, bus.mem_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = $urandom & 32'hFFFF_FFF0;
    for (int i = 0; i < 8; i++) genLegal(gc[i], gs[i], gd[i], gi[i]);
    clearMon();
    okAll = 1'b1;
    stopRand = 1'b0;
    pulseStart(base, 16'd8);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          sendReq(gc[i], gs[i], gd[i], gi[i], ok);
          if (!ok) okAll = 1'b0;
        end
        bus.req_valid = 1'b0;
        stopRand = 1'b1;
      end
      begin
        while (!stopRand) begin
          bus.mem_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        bus.mem_ready = 1'b1;
      end
    join
    waitDone(100, dok);
    testsRun++; if (!okAll || !dok) begin testsFailed++; $display("[TB] FAIL rand_progress: acc %b done %b expected 1 1", okAll, dok); end
    testsRun++; if (capData.size() != 8) begin testsFailed++; $display("[TB] FAIL rand_count: got %0d writes expected 8", capData.size()); end
    for (int i = 0; i < 8 && i < capData.size(); i++) begin
      refDecode(capData[i], dOpc, dCode, dRs1, dRd, dImm);
      testsRun++; if (dOpc !== 7'h13 || dCode !== gc[i] || dRs1 !== gs[i] || dRd !== gd[i] || dImm !== gi[i]) begin
        testsFailed++;
        $display("[TB] FAIL rand_roundtrip%0d: got op %h code %0d rs1 %0d rd %0d imm %h expected op 13 code %0d rs1 %0d rd %0d imm %h",
                 i, dOpc, dCode, dRs1, dRd, dImm, gc[i], gs[i], gd[i], gi[i]);
      end
      testsRun++; if (capAddr[i] !== base + 32'(4 * i)) begin testsFailed++; $display("[TB] FAIL rand_addr%0d: got %h expected %h", i, capAddr[i], base + 32'(4 * i)); end
    end
    testsRun++; if (stallViol != 0) begin testsFailed++; $display("[TB] FAIL rand_held_stable: got %0d changes expected 0", stallViol); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.inst_count = '0;
    bus.req_valid = 1'b0;
    bus.req_alu_control = '0;
    bus.req_rs1 = '0;
    bus.req_rd = '0;
    bus.req_imm = '0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_addi_single();
    test_shift_error();
    test_back_to_back();
    test_wrap();
    test_zero_count();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
